// File: rtl/int_responder_pkg.sv
// int_pkg: shared definitions for the int_responder interrupt source.
//   state_e    - interrupt handshake FSM states
//   ACK_OFS    - byte offset of the ACK/STATUS word from the block base
//   CTRL_OFS   - byte offset of the CTRL word from the block base
//   INT_BIT    - STATUS bit carrying the live interrupt level
//   EN_BIT     - STATUS bit mirroring the source enable
//   word_addr  - strips the byte-lane bits from a bus address
package int_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  localparam logic [31:0] ACK_OFS  = 32'd0;
  localparam logic [31:0] CTRL_OFS = 32'd4;

  localparam int INT_BIT = 31;
  localparam int EN_BIT  = 30;

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/int_responder_if.sv
// int_responder_if: CPU external-bus view of the interrupt source.
//   addr      - byte address from the CPU (low two bits ignored by the device)
//   wdata     - store data
//   byteen    - byte enables; nonzero marks a store this cycle
//   rdata     - combinational read data for addr
//   interrupt - registered level interrupt request
// master: CPU/bridge side.  slave: int_responder side.
interface int_responder_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byteen;
  logic [31:0] rdata;
  logic        interrupt;

  modport master (
    output addr,
    output wdata,
    output byteen,
    input  rdata,
    input  interrupt
  );

  modport slave (
    input  addr,
    input  wdata,
    input  byteen,
    output rdata,
    output interrupt
  );
endinterface

// File: rtl/int_responder_sat_updown_cnt.sv
// sat_updown_cnt: W-bit unsigned up/down counter that sticks at both ends.
//   clk   - clock, rising edge
//   reset - asynchronous active-high clear
//   inc   - count up by one (ignored at all-ones)
//   dec   - count down by one (ignored at zero)
//   count - registered count
// inc and dec together cancel and leave the count unchanged.
module sat_updown_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec && (count_q != CNT_MAX)) begin
      count_d = count_q + W'(1);
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/int_responder.sv
// int_responder: memory-mapped interrupt source.
// Counts event_req pulses, raises a level interrupt while events are pending
// and enabled, and retires one event per CPU store to the ACK word.
//   clk       - system clock, rising edge
//   reset     - asynchronous active-high reset
//   event_req - one sampled high cycle is one event
//   bus       - slave side of int_responder_if (addr/wdata/byteen/rdata/interrupt)
// Register map (word aligned):
//   BASE_ADDR+0 ACK/STATUS  R: [31]=interrupt [30]=enable [CNT_W-1:0]=pending
//                           W: any store acknowledges one event
//   BASE_ADDR+4 CTRL        R/W: [0]=enable (written from byte lane 0 only)
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | interrupt low; waiting for enable and a nonzero pending count
// ST_ASSERT  | interrupt high; waiting for an ack store or a disable
// ST_HOLDOFF | interrupt forced low after an ack while holdoff_cnt runs out
module int_responder
  import int_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7f20,
  parameter int          CNT_W     = 4,
  parameter int          HOLDOFF   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            event_req,
  int_responder_if.slave  bus
);

  localparam int HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HO_W-1:0] HO_LOAD = (HOLDOFF > 0) ? HO_W'(HOLDOFF - 1) : '0;

  localparam logic [31:0] ACK_ADDR  = BASE_ADDR + ACK_OFS;
  localparam logic [31:0] CTRL_ADDR = BASE_ADDR + CTRL_OFS;

  logic [31:0] word_a;
  logic        wr_any;
  logic        ack_hit;
  logic        ctrl_hit;
  logic        en_wr;

  state_e          state_q, state_d;
  logic            enable_q, enable_d;
  logic [HO_W-1:0] holdoff_cnt_q, holdoff_cnt_d;
  logic            interrupt_q, interrupt_d;

  logic [CNT_W-1:0] pending;
  logic             inc;
  logic             dec;
  logic [31:0]      rdata_c;

  logic unused_wdata;
  assign unused_wdata = ^bus.wdata[31:1];

  assign word_a   = word_addr(bus.addr);
  assign wr_any   = |bus.byteen;
  assign ack_hit  = wr_any && (word_a == ACK_ADDR);
  assign ctrl_hit = wr_any && (word_a == CTRL_ADDR);
  assign en_wr    = ctrl_hit && bus.byteen[0];

  // Acks outside ST_ASSERT are spurious and must not retire an event.
  assign inc = event_req && enable_q;
  assign dec = ack_hit && (state_q == ST_ASSERT) && (pending != '0);

  sat_updown_cnt #(
    .W (CNT_W)
  ) u_pending (
    .clk   (clk),
    .reset (reset),
    .inc   (inc),
    .dec   (dec),
    .count (pending)
  );

  always_comb begin
    state_d       = state_q;
    holdoff_cnt_d = holdoff_cnt_q;
    enable_d      = enable_q;

    if (en_wr) begin
      enable_d = bus.wdata[0];
    end

    case (state_q)
      ST_IDLE: begin
        // Registered pending/enable: a new event shows up one edge later.
        if (enable_q && (pending != '0)) begin
          state_d = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        // Ack wins over a disable in the same store cycle.
        if (ack_hit) begin
          if (HOLDOFF == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d       = ST_HOLDOFF;
            holdoff_cnt_d = HO_LOAD;
          end
        end else if (en_wr && !bus.wdata[0]) begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLDOFF: begin
        if (holdoff_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          holdoff_cnt_d = holdoff_cnt_q - HO_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    interrupt_d = (state_d == ST_ASSERT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      holdoff_cnt_q <= '0;
      enable_q      <= 1'b1;
      interrupt_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      holdoff_cnt_q <= holdoff_cnt_d;
      enable_q      <= enable_d;
      interrupt_q   <= interrupt_d;
    end
  end

  always_comb begin
    rdata_c = '0;
    if (word_a == ACK_ADDR) begin
      rdata_c[INT_BIT]     = interrupt_q;
      rdata_c[EN_BIT]      = enable_q;
      rdata_c[CNT_W-1:0]   = pending;
    end else if (word_a == CTRL_ADDR) begin
      rdata_c[0] = enable_q;
    end
  end

  assign bus.rdata     = rdata_c;
  assign bus.interrupt = interrupt_q;

endmodule

// File: tb/tb_int_responder.sv
module tb_int_responder;

  localparam logic [31:0] BASE    = 32'h0000_7f20;
  localparam int          CNT_W   = 4;
  localparam int          HOLDOFF = 2;
  localparam int          PMAX    = (1 << CNT_W) - 1;

  logic clk;
  logic reset;
  logic event_req;

  int_responder_if bus ();

  int_responder #(
    .BASE_ADDR (BASE),
    .CNT_W     (CNT_W),
    .HOLDOFF   (HOLDOFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .event_req (event_req),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: event count, enable bit, interrupt level and the number
  // of edges left before the source may fire again after an acknowledge.
  int m_pend;
  bit m_en;
  bit m_int;
  int m_wait;

  function automatic void model_reset();
    m_pend = 0;
    m_en   = 1'b1;
    m_int  = 1'b0;
    m_wait = 0;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] r;
    w = a & 32'hFFFF_FFFC;
    r = 32'd0;
    if (w == BASE) begin
      r = (32'(m_int) << 31) | (32'(m_en) << 30) | 32'(m_pend);
    end else if (w == BASE + 32'd4) begin
      r = 32'(m_en);
    end
    return r;
  endfunction

  function automatic void model_edge(input bit ev, input logic [31:0] a,
                                     input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] w;
    bit ack;
    bit ctl;
    int old_pend;
    bit old_en;
    int np;
    w        = a & 32'hFFFF_FFFC;
    ack      = (be != 4'd0) && (w == BASE);
    ctl      = (be != 4'd0) && (w == BASE + 32'd4) && be[0];
    old_pend = m_pend;
    old_en   = m_en;

    np = old_pend;
    if (ev && old_en) np = np + 1;
    if (ack && m_int && old_pend > 0) np = np - 1;
    if (np > PMAX) np = PMAX;
    if (np < 0) np = 0;
    m_pend = np;

    if (m_int) begin
      if (ack) begin
        m_int  = 1'b0;
        m_wait = HOLDOFF;
      end else if (ctl && !wd[0]) begin
        m_int  = 1'b0;
        m_wait = 0;
      end
    end else if (m_wait > 0) begin
      m_wait = m_wait - 1;
    end else if (old_en && old_pend > 0) begin
      m_int = 1'b1;
    end

    if (ctl) m_en = wd[0];
  endfunction

  task automatic cycle(input bit ev, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] er;
    event_req  = ev;
    bus.addr   = a;
    bus.wdata  = wd;
    bus.byteen = be;
    #1;
    er = exp_rdata(a);
    checks++;
    assert (bus.rdata === er) else begin
      failures++;
      $error("FAIL rdata addr=%h observed=%h expected=%h", a, bus.rdata, er);
    end
    @(posedge clk);
    model_edge(ev, a, wd, be);
    #1;
    checks++;
    assert (bus.interrupt === m_int) else begin
      failures++;
      $error("FAIL interrupt t=%0t observed=%b expected=%b", $time, bus.interrupt, m_int);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, BASE, 32'd0, 4'd0);
  endtask

  task automatic check_status(input string tag, input logic [31:0] expv);
    bus.addr   = BASE;
    bus.byteen = 4'd0;
    #1;
    checks++;
    assert (bus.rdata === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, bus.rdata, expv);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    bit          ev;
    int          op;

    model_reset();
    reset      = 1'b1;
    event_req  = 1'b0;
    bus.addr   = BASE;
    bus.wdata  = 32'd0;
    bus.byteen = 4'd0;
    #10;
    check_status("reset_status", 32'h4000_0000);
    checks++;
    assert (bus.interrupt === 1'b0) else begin
      failures++;
      $error("FAIL reset_int observed=%b expected=0", bus.interrupt);
    end
    #9;
    reset = 1'b0;

    // Single event then acknowledge.
    cycle(1'b1, BASE, 32'd0, 4'd0);
    cycle(1'b0, BASE, 32'd0, 4'd0);
    check_status("one_event_status", 32'hC000_0001);
    cycle(1'b0, BASE, 32'd0, 4'hf);
    check_status("after_ack_status", 32'h4000_0000);
    idle(6);

    // Three events, drained one ack at a time through the holdoff window.
    for (int i = 0; i < 3; i++) cycle(1'b1, BASE, 32'd0, 4'd0);
    idle(1);
    check_status("three_events_status", 32'hC000_0003);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, BASE, 32'd0, 4'hf);
      idle(4);
    end
    check_status("drained_status", 32'h4000_0000);

    // Saturation, then ack coinciding with an event.
    for (int i = 0; i < 20; i++) cycle(1'b1, BASE, 32'd0, 4'd0);
    check_status("saturated_status", 32'hC000_000F);
    cycle(1'b1, BASE, 32'd0, 4'hf);
    check_status("ack_plus_event_status", 32'h4000_000F);
    idle(4);

    // Disable while asserted, events ignored, then re-enable.
    cycle(1'b0, BASE + 32'd4, 32'd0, 4'h1);
    check_status("disabled_status", 32'h0000_000F);
    for (int i = 0; i < 3; i++) cycle(1'b1, BASE, 32'd0, 4'd0);
    cycle(1'b0, BASE + 32'd4, 32'd1, 4'h1);
    idle(2);
    check_status("reenabled_status", 32'hC000_000F);

    // Asynchronous reset between edges while asserted.
    #2;
    reset = 1'b1;
    model_reset();
    check_status("async_reset_status", 32'h4000_0000);
    checks++;
    assert (bus.interrupt === 1'b0) else begin
      failures++;
      $error("FAIL async_reset_int observed=%b expected=0", bus.interrupt);
    end
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      ev = ($urandom_range(0, 2) != 0);
      op = $urandom_range(0, 9);
      wd = $urandom();
      be = 4'd0;
      a  = BASE;
      case (op)
        0, 1, 2: begin
          a  = BASE | 32'($urandom_range(0, 3));
          be = 4'($urandom_range(1, 15));
        end
        3: begin
          a  = BASE + 32'd4 + 32'($urandom_range(0, 3));
          be = 4'($urandom_range(1, 15));
          if ($urandom_range(0, 3) != 0) wd[0] = 1'b1;
        end
        4: begin
          a  = BASE + 32'd8;
          be = 4'($urandom_range(1, 15));
        end
        5: a = BASE + 32'd4;
        6: a = 32'h0000_1000;
        default: a = BASE;
      endcase
      cycle(ev, a, wd, be);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
